// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, default address width and
// the fetch-side FSM state type.
package y86_pkg;

    localparam int ADDR_W_DEF = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_RET_WAIT = 2'd1,
        S_HALT     = 2'd2
    } fetch_state_t;

    // Jumps are predicted taken and calls always go to their target.
    function automatic logic predicts_valc(input logic [3:0] icode);
        return (icode == I_JXX) || (icode == I_CALL);
    endfunction

endpackage

// File: rtl/fetch_pc_select_pc_predict.sv
// Next-PC predictor for the fetched instruction: target for jumps and calls,
// fall-through address for everything else.
module pc_predict
    import y86_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [3:0]        i_icode,
    input  logic [ADDR_W-1:0] i_valC,
    input  logic [ADDR_W-1:0] i_valP,
    output logic [ADDR_W-1:0] o_pred
);

    assign o_pred = predicts_valc(i_icode) ? i_valC : i_valP;

endmodule

// File: rtl/fetch_pc_select.sv
// Fetch-stage PC selection: holds the predicted PC, redirects on mispredicted
// jumps and completed returns, and tracks ret/halt stalls for decode.
module fetch_pc_select
    import y86_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        f_icode,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    input  logic [3:0]        M_icode,
    input  logic              M_cnd,
    input  logic [ADDR_W-1:0] M_valA,
    input  logic [3:0]        W_icode,
    input  logic [ADDR_W-1:0] W_valM,
    input  logic              stall_in,
    output logic [ADDR_W-1:0] f_pc,
    output logic [ADDR_W-1:0] pred_pc,
    output logic              d_bubble,
    output logic              halted
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pred_pc;
    logic              r_halted;

    logic              w_mispredict;
    logic              w_ret_done;
    logic [ADDR_W-1:0] w_pred_next;
    logic              w_d_bubble;

    assign w_mispredict = (M_icode == I_JXX) && !M_cnd;
    assign w_ret_done   = (W_icode == I_RET);

    assign f_pc = w_mispredict ? M_valA :
                  w_ret_done   ? W_valM :
                                 r_pred_pc;

    // f_icode/f_valC/f_valP always describe the instruction at f_pc, so this
    // single predictor also yields the prediction after a redirect.
    pc_predict #(
        .ADDR_W (ADDR_W)
    ) u_pc_predict (
        .i_icode (f_icode),
        .i_valC  (f_valC),
        .i_valP  (f_valP),
        .o_pred  (w_pred_next)
    );

    always_comb begin
        w_d_bubble = 1'b0;
        case (r_state)
            S_RUN:      w_d_bubble = w_mispredict;
            S_RET_WAIT: w_d_bubble = w_mispredict || !w_ret_done;
            S_HALT:     w_d_bubble = 1'b1;
            default:    w_d_bubble = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RUN;
            r_pred_pc <= RESET_PC;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mispredict) begin
                        r_pred_pc <= w_pred_next;
                    end else if (!stall_in) begin
                        if (f_icode == I_RET) begin
                            r_state <= S_RET_WAIT;
                        end else if (f_icode == I_HALT) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_pred_pc <= w_pred_next;
                        end
                    end
                end
                S_RET_WAIT: begin
                    if (w_mispredict) begin
                        r_pred_pc <= w_pred_next;
                        r_state   <= S_RUN;
                    end else if (w_ret_done) begin
                        // A ret landing on another ret waits again at once.
                        r_pred_pc <= w_pred_next;
                        r_state   <= (f_icode == I_RET) ? S_RET_WAIT : S_RUN;
                    end
                end
                S_HALT: begin
                    if (w_mispredict) begin
                        r_pred_pc <= w_pred_next;
                        r_state   <= S_RUN;
                        r_halted  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign pred_pc  = r_pred_pc;
    assign d_bubble = w_d_bubble;
    assign halted   = r_halted;

endmodule

// File: tb/tb_fetch_pc_select.sv
// Bench for fetch_pc_select: directed vector table for the multi-cycle
// corner cases, then randomized cycles against a behavioural model.
module tb_fetch_pc_select;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  f_icode;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic        stall_in;
    logic [63:0] f_pc;
    logic [63:0] pred_pc;
    logic        d_bubble;
    logic        halted;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    fetch_pc_select dut (
        .clk      (clk),
        .reset    (reset),
        .f_icode  (f_icode),
        .f_valC   (f_valC),
        .f_valP   (f_valP),
        .M_icode  (M_icode),
        .M_cnd    (M_cnd),
        .M_valA   (M_valA),
        .W_icode  (W_icode),
        .W_valM   (W_valM),
        .stall_in (stall_in),
        .f_pc     (f_pc),
        .pred_pc  (pred_pc),
        .d_bubble (d_bubble),
        .halted   (halted)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  fIc;
        logic [63:0] fC;
        logic [63:0] fP;
        logic [3:0]  mIc;
        logic        mCnd;
        logic [63:0] mA;
        logic [3:0]  wIc;
        logic [63:0] wM;
        logic        stall;
        logic        chkComb;
        logic [63:0] expFpc;
        logic        expDb;
        logic [63:0] expPred;
        logic        expHalt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(
        input logic rst, input logic [3:0] fIc, input logic [63:0] fC, input logic [63:0] fP,
        input logic [3:0] mIc, input logic mCnd, input logic [63:0] mA,
        input logic [3:0] wIc, input logic [63:0] wM, input logic stall,
        input logic chkComb, input logic [63:0] expFpc, input logic expDb,
        input logic [63:0] expPred, input logic expHalt);
        vec_t v;
        v.rst = rst; v.fIc = fIc; v.fC = fC; v.fP = fP;
        v.mIc = mIc; v.mCnd = mCnd; v.mA = mA;
        v.wIc = wIc; v.wM = wM; v.stall = stall;
        v.chkComb = chkComb; v.expFpc = expFpc; v.expDb = expDb;
        v.expPred = expPred; v.expHalt = expHalt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        reset    = v.rst;
        f_icode  = v.fIc;
        f_valC   = v.fC;
        f_valP   = v.fP;
        M_icode  = v.mIc;
        M_cnd    = v.mCnd;
        M_valA   = v.mA;
        W_icode  = v.wIc;
        W_valM   = v.wM;
        stall_in = v.stall;
    endtask

    // Behavioural model: fetch is either running, waiting on a ret, or stopped.
    logic [63:0] mPred;
    bit          mWaiting;
    bit          mStopped;

    initial begin
        vec_t v;
        bit mis, rd;
        logic [63:0] guess, expFpc;
        bit expDb;
        int r;

        reset = 1'b1; f_icode = 4'h1; f_valC = '0; f_valP = '0;
        M_icode = 4'h1; M_cnd = 1'b0; M_valA = '0;
        W_icode = 4'h1; W_valM = '0; stall_in = 1'b0;

        //                rst fIc  fC     fP      mIc mCnd mA     wIc wM      stl chk  fpc     db  pred    hlt
        vecs.push_back(mkVec(1, 1, 0,      0,      1, 0, 0,      1, 0,      0,  0,   0,      0,  0,      0));
        vecs.push_back(mkVec(1, 1, 0,      0,      1, 0, 0,      1, 0,      0,  1,   0,      0,  0,      0));
        vecs.push_back(mkVec(0, 1, 0,      'h1,    1, 0, 0,      1, 0,      0,  1,   0,      0,  'h1,    0));
        vecs.push_back(mkVec(0, 7, 'h40,   'h9,    1, 0, 0,      1, 0,      0,  1,   'h1,    0,  'h40,   0));
        vecs.push_back(mkVec(0, 1, 0,      'h42,   1, 0, 0,      1, 0,      0,  1,   'h40,   0,  'h42,   0));
        vecs.push_back(mkVec(0, 1, 0,      'hA,    7, 0, 'h9,    1, 0,      0,  1,   'h9,    1,  'hA,    0));
        vecs.push_back(mkVec(0, 8, 'h20,   'h13,   1, 0, 0,      1, 0,      0,  1,   'hA,    0,  'h20,   0));
        vecs.push_back(mkVec(0, 9, 0,      'h21,   1, 0, 0,      1, 0,      0,  1,   'h20,   0,  'h20,   0));
        vecs.push_back(mkVec(0, 1, 0,      'h21,   1, 0, 0,      1, 0,      0,  1,   'h20,   1,  'h20,   0));
        vecs.push_back(mkVec(0, 1, 0,      'h21,   1, 0, 0,      1, 0,      1,  1,   'h20,   1,  'h20,   0));
        vecs.push_back(mkVec(0, 1, 0,      'h21,   1, 0, 0,      1, 0,      0,  1,   'h20,   1,  'h20,   0));
        vecs.push_back(mkVec(0, 1, 0,      'h101,  1, 0, 0,      9, 'h100,  0,  1,   'h100,  0,  'h101,  0));
        vecs.push_back(mkVec(0, 7, 'h30,   'h10A,  1, 0, 0,      1, 0,      0,  1,   'h101,  0,  'h30,   0));
        vecs.push_back(mkVec(0, 1, 0,      'h31,   1, 0, 0,      1, 0,      1,  1,   'h30,   0,  'h30,   0));
        vecs.push_back(mkVec(0, 1, 0,      'h31,   1, 0, 0,      1, 0,      1,  1,   'h30,   0,  'h30,   0));
        vecs.push_back(mkVec(0, 1, 0,      'h31,   1, 0, 0,      1, 0,      0,  1,   'h30,   0,  'h31,   0));
        vecs.push_back(mkVec(0, 0, 0,      'h32,   1, 0, 0,      1, 0,      0,  1,   'h31,   0,  'h31,   1));
        vecs.push_back(mkVec(0, 1, 0,      'h32,   1, 0, 0,      1, 0,      0,  1,   'h31,   1,  'h31,   1));
        vecs.push_back(mkVec(0, 1, 0,      'h51,   7, 0, 'h50,   1, 0,      0,  1,   'h50,   1,  'h51,   0));
        vecs.push_back(mkVec(0, 1, 0,      'h61,   7, 0, 'h60,   9, 'h70,   0,  1,   'h60,   1,  'h61,   0));
        vecs.push_back(mkVec(0, 9, 0,      'h62,   1, 0, 0,      1, 0,      0,  1,   'h61,   0,  'h61,   0));
        vecs.push_back(mkVec(0, 9, 0,      'h201,  1, 0, 0,      9, 'h200,  0,  1,   'h200,  0,  'h201,  0));
        vecs.push_back(mkVec(0, 1, 0,      'h202,  1, 0, 0,      1, 0,      0,  1,   'h201,  1,  'h201,  0));
        vecs.push_back(mkVec(0, 1, 0,      'h81,   7, 0, 'h80,   1, 0,      0,  1,   'h80,   1,  'h81,   0));
        vecs.push_back(mkVec(0, 1, 0,      'h82,   1, 0, 0,      1, 0,      0,  1,   'h81,   0,  'h82,   0));
        vecs.push_back(mkVec(0, 0, 0,      'h83,   1, 0, 0,      1, 0,      0,  1,   'h82,   0,  'h82,   1));
        vecs.push_back(mkVec(1, 7, 'h99,   'h91,   7, 0, 'h90,   1, 0,      0,  1,   'h90,   1,  'h0,    0));
        vecs.push_back(mkVec(0, 1, 0,      'h5,    1, 0, 0,      1, 0,      0,  1,   'h0,    0,  'h5,    0));
        vecs.push_back(mkVec(0, 1, 0,      'h6,    7, 1, 'h77,   1, 0,      0,  1,   'h5,    0,  'h6,    0));
        vecs.push_back(mkVec(0, 1, 0,      'h0,    1, 0, 0,      1, 0,      0,  1,   'h6,    0,  'h0,    0));

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            if (vecs[i].chkComb) begin
                checkOutput($sformatf("vec%0d f_pc", i), f_pc, vecs[i].expFpc);
                checkOutput($sformatf("vec%0d d_bubble", i), {63'd0, d_bubble}, {63'd0, vecs[i].expDb});
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d pred_pc", i), pred_pc, vecs[i].expPred);
            checkOutput($sformatf("vec%0d halted", i), {63'd0, halted}, {63'd0, vecs[i].expHalt});
        end

        mPred = '0; mWaiting = 0; mStopped = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            v.rst   = (c == 0) || ($urandom_range(0, 99) < 2);
            r       = $urandom_range(0, 99);
            v.fIc   = (r < 5) ? 4'h0 : (r < 20) ? 4'h9 : (r < 35) ? 4'h7 :
                      (r < 45) ? 4'h8 : 4'($urandom_range(1, 11));
            v.fC    = {$urandom(), $urandom()};
            v.fP    = {$urandom(), $urandom()};
            v.mIc   = ($urandom_range(0, 99) < 20) ? 4'h7 : 4'($urandom_range(0, 6));
            v.mCnd  = 1'($urandom_range(0, 1));
            v.mA    = {$urandom(), $urandom()};
            v.wIc   = (mWaiting && $urandom_range(0, 99) < 35) ? 4'h9 : 4'($urandom_range(0, 8));
            v.wM    = {$urandom(), $urandom()};
            v.stall = ($urandom_range(0, 99) < 20);
            applyStimulus(v);

            mis    = (v.mIc == 4'h7) && !v.mCnd;
            rd     = (v.wIc == 4'h9);
            expFpc = mis ? v.mA : rd ? v.wM : mPred;
            expDb  = mis || mStopped || (mWaiting && !rd);
            guess  = (v.fIc == 4'h7 || v.fIc == 4'h8) ? v.fC : v.fP;

            #1;
            if (c != 0) begin
                checkOutput($sformatf("rand%0d f_pc", c), f_pc, expFpc);
                checkOutput($sformatf("rand%0d d_bubble", c), {63'd0, d_bubble}, {63'd0, expDb});
            end

            if (v.rst) begin
                mPred = '0; mWaiting = 0; mStopped = 0;
            end else if (mStopped) begin
                if (mis) begin mStopped = 0; mPred = guess; end
            end else if (mWaiting) begin
                if (mis) begin mWaiting = 0; mPred = guess; end
                else if (rd) begin mPred = guess; mWaiting = (v.fIc == 4'h9); end
            end else begin
                if (mis) mPred = guess;
                else if (v.stall) ;
                else if (v.fIc == 4'h9) mWaiting = 1;
                else if (v.fIc == 4'h0) mStopped = 1;
                else mPred = guess;
            end

            @(posedge clk);
            #1;
            checkOutput($sformatf("rand%0d pred_pc", c), pred_pc, mPred);
            checkOutput($sformatf("rand%0d halted", c), {63'd0, halted}, {63'd0, 63'd0 + mStopped});
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
